jtcop_bus_resp: RTL

//  Responder side of the main 68000 bus. Once the address decoder raises a chip select, this block

---
 rtl/jtcop_bus_resp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jtcop_bus_resp.sv
// Responder for the main 68000 bus: terminates chip-selected cycles with DTACKn or BERRn,
// gating on SDRAM ok flags, a minimum wait-state count and a timeout.
module jtcop_bus_resp #(
  parameter int unsigned MINWAIT = 2,
  parameter int unsigned OKDLY   = 2,
  parameter int unsigned TOUT    = 255
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cpu_cen,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic        RnW,
  input  logic [2:0]  FC,
  input  logic        rom_cs,
  input  logic        ram_cs,
  input  logic        vram_cs,
  input  logic        io_cs,
  input  logic        rom_ok,
  input  logic        ram_ok,
  input  logic [15:0] rom_data,
  input  logic [15:0] ram_data,
  input  logic [15:0] io_data,
  output logic        DTACKn,
  output logic        BERRn,
  output logic [15:0] cpu_din,
  output logic        busy
);

  localparam logic [3:0] WaitMax = 4'(MINWAIT);
  localparam logic [7:0] OkMax   = 8'(OKDLY);
  localparam logic [7:0] ToMax   = 8'(TOUT);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StBerr} state_e;

  state_e      state_q, state_d;
  logic [3:0]  waitcnt_q, waitcnt_d;
  logic [7:0]  okdly_q, okdly_d;
  logic [7:0]  tocnt_q, tocnt_d;
  logic        armed_q, armed_d;
  logic [15:0] din_q, din_d;
  logic        dtackn_q, dtackn_d;
  logic        berrn_q, berrn_d;

  logic        sel_rom, sel_ram, sel_io, sdram_src;
  logic        src_ok, go_ack, go_berr, cycle_start;
  logic [15:0] src_data;

  // Source priority: ROM, then RAM/VRAM, then IO, otherwise open bus.
  always_comb begin
    sel_rom   = rom_cs;
    sel_ram   = !rom_cs && (ram_cs || vram_cs);
    sel_io    = !rom_cs && !ram_cs && !vram_cs && io_cs;
    sdram_src = sel_rom || sel_ram;
    src_ok    = 1'b1;
    src_data  = 16'hFFFF;
    if (sel_rom) begin
      src_ok   = (okdly_q == OkMax) && rom_ok;
      src_data = rom_data;
    end else if (sel_ram) begin
      src_ok   = (okdly_q == OkMax) && ram_ok;
      src_data = ram_data;
    end else if (sel_io) begin
      src_data = io_data;
    end
    go_ack  = (waitcnt_q == WaitMax) && src_ok;
    go_berr = sdram_src && (tocnt_q == ToMax) && !go_ack;
    // armed_q guarantees at least one IDLE clk with ASn high before a new cycle.
    cycle_start = armed_q && !ASn && !(UDSn && LDSn) && (FC != 3'b111);
  end

  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    okdly_d   = okdly_q;
    tocnt_d   = tocnt_q;
    armed_d   = armed_q;
    din_d     = din_q;
    case (state_q)
      StIdle: begin
        armed_d = armed_q | ASn;
        if (cycle_start) begin
          state_d   = StWait;
          waitcnt_d = '0;
          okdly_d   = '0;
          tocnt_d   = '0;
          armed_d   = 1'b0;
        end
      end
      StWait: begin
        if (cpu_cen && waitcnt_q != WaitMax) waitcnt_d = waitcnt_q + 4'd1;
        if (okdly_q != OkMax) okdly_d = okdly_q + 8'd1;
        if (sdram_src && cpu_cen && tocnt_q != ToMax) tocnt_d = tocnt_q + 8'd1;
        if (ASn) begin
          state_d = StIdle;
        end else if (go_ack) begin
          state_d = StAck;
          if (RnW) din_d = src_data;
        end else if (go_berr) begin
          state_d = StBerr;
        end
      end
      StAck, StBerr: begin
        if (ASn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    dtackn_d = (state_d != StAck);
    berrn_d  = (state_d != StBerr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      waitcnt_q <= '0;
      okdly_q   <= '0;
      tocnt_q   <= '0;
      armed_q   <= 1'b0;
      din_q     <= 16'hFFFF;
      dtackn_q  <= 1'b1;
      berrn_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      okdly_q   <= okdly_d;
      tocnt_q   <= tocnt_d;
      armed_q   <= armed_d;
      din_q     <= din_d;
      dtackn_q  <= dtackn_d;
      berrn_q   <= berrn_d;
    end
  end

  assign DTACKn  = dtackn_q;
  assign BERRn   = berrn_q;
  assign cpu_din = din_q;
  assign busy    = (state_q != StIdle);

endmodule
